hilo_muldiv_ctrl: RTL and testbench
===================================

// Module: hilo_muldiv_ctrl
// PURPOSE
//   Iterative multiply/divide sequencer owning the HI/LO register pair for the pipelined CPU.
//   Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs a 32-step shift-add or restoring-divide loop.
//   Asserts stall to the hazard unit while a later HI/LO access or new mul/div collides with a running op.
// PARAMETERS
//   WIDTH  32  operand width; iteration count = WIDTH; HI/LO are WIDTH bits each
// PORTS
//   clk       in   1      system clock, all state updates on rising edge
//   reset     in   1      synchronous, active-high reset
//   start     in   1      EX-stage request valid (one-cycle pulse per instruction)
//   op        in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 ignored
//   rs        in   WIDTH  operand A / dividend / MTHI-MTLO data
//   rt        in   WIDTH  operand B / divisor
//   hiloRead  in   1      ID-stage instruction is MFHI/MFLO
//   flush     in   1      cancel in-flight op (exception/branch squash)
//   hi        out  WIDTH  HI register
//   lo        out  WIDTH  LO register
//   busy      out  1      iterative op in progress
//   stall     out  1      busy & (hiloRead | start); combinational
// BEHAVIOUR
//   Reset: state IDLE, hi=0, lo=0, busy=0, count=0, all iteration registers cleared.
//   Reset takes priority over everything, including mid-operation; in-flight result discarded.
//   FSM: IDLE -> RUN (start & op in 0..3) -> FIX -> IDLE.
//   - IDLE: MTHI/MTLO write hi/lo from rs at the accepting edge; busy stays 0; state stays IDLE.
//   - IDLE: op 0-3 latches |rs|,|rt| (signed ops) or raw rs,rt (unsigned), resultNeg/remNeg flags; count=WIDTH-1.
//   - RUN: one iteration per cycle; count decrements; leave to FIX when count==0 (WIDTH cycles in RUN).
//   - FIX: conditional two's-complement negation, write hi/lo, return IDLE.
//   Latency: start accepted at edge E0; hi/lo valid and busy=0 after edge E0+WIDTH+1 (33 cycles busy).
//   busy=1 exactly in RUN and FIX; hi/lo hold old values until the FIX edge (no partial updates visible).
//   Multiply: 2*WIDTH-bit product {hi,lo}; signed result negated in FIX if sign(rs)^sign(rt).
//   Divide: lo=quotient, hi=remainder; quotient sign = sign(rs)^sign(rt); remainder sign = sign(rs).
//   Divide by zero: lo={WIDTH{1}}, hi=rs (signed too, no negation); same latency.
//   Signed overflow 0x80000000 / -1: lo=0x80000000, hi=0 (falls out of magnitude arithmetic).
//   start while busy: ignored (not queued); the requester is stalled and must re-present it.
//   start and hiloRead together while busy: stall=1, no state change.
//   MFHI/MFLO when idle: stall=0; hi/lo read directly (read of same-cycle MTHI write is forwarded elsewhere).
//   flush: in RUN/FIX returns to IDLE next edge, hi/lo unchanged, busy=0; in IDLE it blocks start that cycle.
//   op 6-7 with start: no effect.
// TESTING
//   MULTU rs=111111 rt=222222 -> after 33 busy cycles hi=0x00000005 lo=0xBFB77862.
//   MULT rs=-111111 rt=222222 -> hi=0xFFFFFFFA lo=0x4048879E.
//   DIV rs=-7 rt=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU rs=100 rt=7 -> lo=14 hi=2.
//   DIV rs=5 rt=0 -> lo=0xFFFFFFFF hi=5; DIV rs=0x80000000 rt=0xFFFFFFFF -> lo=0x80000000 hi=0.
//   MULTU then hiloRead=1 on cycle 2 -> stall=1 until busy falls; MTLO during busy ignored, lo = product.
//   reset at RUN cycle 10 -> next edge hi=lo=0 busy=0; flush at RUN cycle 10 -> hi/lo keep prior values.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning the HI/LO register pair.
// One shift-add or restoring-divide step per cycle; sign correction and HI/LO write in FIX.
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             hiloRead,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic               is_div_q, is_div_d;
  logic               res_neg_q, res_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               div_zero_q, div_zero_d;

  logic               op_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next;

  assign op_signed = ~op[0];
  assign a_mag     = (op_signed && rs[WIDTH-1]) ? -rs : rs;
  assign b_mag     = (op_signed && rt[WIDTH-1]) ? -rt : rt;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
  assign mul_next  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, b_q};
  assign div_next  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through this block infers a latch.
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    b_d        = b_q;
    acc_d      = acc_q;
    count_d    = count_q;
    is_div_d   = is_div_q;
    res_neg_d  = res_neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          if (op == 3'd4) begin
            hi_d = rs;
          end else if (op == 3'd5) begin
            lo_d = rs;
          end else if (!op[2]) begin
            state_d    = RUN;
            is_div_d   = op[1];
            acc_d      = {{WIDTH{1'b0}}, a_mag};
            b_d        = b_mag;
            count_d    = CW'(WIDTH - 1);
            res_neg_d  = op_signed && (rs[WIDTH-1] ^ rt[WIDTH-1]);
            rem_neg_d  = op_signed && rs[WIDTH-1];
            div_zero_d = (rt == '0);
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          if (count_q == '0) state_d = FIX;
          else               count_d = count_q - CW'(1);
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          if (is_div_q) begin
            lo_d = div_zero_q ? {WIDTH{1'b1}}
                 : (res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
            hi_d = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          end else begin
            {hi_d, lo_d} = res_neg_q ? -acc_q : acc_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
    if (reset) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      is_div_q   <= 1'b0;
      res_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      is_div_q   <= is_div_d;
      res_neg_q  <= res_neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != IDLE);
  assign stall = busy & (hiloRead | start);

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: expected {hi,lo} queued at issue, popped when busy falls.
module tb_hilo_muldiv_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, hilo_read, flush;
  logic [2:0]   op;
  logic [W-1:0] rs, rt, hi, lo;
  logic         busy, stall;

  int checks   = 0;
  int failures = 0;
  logic [2*W-1:0] exp_q[$];

  hilo_muldiv_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .hiloRead(hilo_read), .flush(flush), .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  // Reference model: returns {hi, lo}.
  function automatic logic [2*W-1:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    int     ia, ib;
    logic [W-1:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = ia / ib;
        r = ia % ib;
        return {r, q};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    logic [2*W-1:0] old_hl, exp_hl;
    int cyc;
    exp_q.push_back(model(o, a, b));
    old_hl = {hi, lo};
    @(negedge clk);
    op = o; rs = a; rt = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_after_accept got=%b exp=1", name, busy); end
    cyc = 1;
    for (int k = 0; k < 100 && busy; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        checks++;
        if ({hi, lo} !== old_hl) begin failures++; $display("FAIL %s partial_update got=%h exp=%h", name, {hi, lo}, old_hl); end
      end
      if (busy) cyc++;
    end
    checks++;
    if (cyc !== 33) begin failures++; $display("FAIL %s busy_cycles got=%0d exp=33", name, cyc); end
    exp_hl = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== exp_hl) begin failures++; $display("FAIL %s result got hi=%h lo=%h exp hi=%h lo=%h", name, hi, lo, exp_hl[63:32], exp_hl[31:0]); end
  endtask

  task automatic write_hilo(input logic [2:0] o, input logic [W-1:0] d, input logic fl, input string name);
    logic [2*W-1:0] exp_hl;
    exp_hl = {hi, lo};
    if (!fl && o == 3'd4) exp_hl[63:32] = d;
    if (!fl && o == 3'd5) exp_hl[31:0]  = d;
    exp_q.push_back(exp_hl);
    @(negedge clk);
    op = o; rs = d; rt = 32'h1234_5678; start = 1'b1; flush = fl;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    exp_hl = exp_q.pop_front();
    checks++;
    if ({hi, lo, busy} !== {exp_hl, 1'b0}) begin
      failures++;
      $display("FAIL %s got hi=%h lo=%h busy=%b exp hi=%h lo=%h busy=0", name, hi, lo, busy, exp_hl[63:32], exp_hl[31:0]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; rs = '0; rt = '0; hilo_read = 1'b1; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({hi, lo, busy, stall} !== {64'd0, 2'b00}) begin
      failures++; $display("FAIL reset got hi=%h lo=%h busy=%b stall=%b exp 0", hi, lo, busy, stall);
    end
    @(negedge clk);
    reset = 1'b0; hilo_read = 1'b0;
  endtask

  task automatic test_mul();
    run_op(3'd1, 32'd111111, 32'd222222, "multu_spec");
    checks++;
    if ({hi, lo} !== 64'h0000_0005_BFB7_7862) begin failures++; $display("FAIL multu_const got=%h exp=00000005bfb77862", {hi, lo}); end
    run_op(3'd0, -32'sd111111, 32'd222222, "mult_neg");
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFA_4048_879E) begin failures++; $display("FAIL mult_const got=%h exp=fffffffa4048879e", {hi, lo}); end
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1m1");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
    for (int i = 0; i < 4; i++) run_op(3'(i % 2), $urandom, $urandom, "mul_rand");
  endtask

  task automatic test_div();
    run_op(3'd2, -32'sd7, 32'd2, "div_neg");
    run_op(3'd3, 32'd100, 32'd7, "divu_small");
    run_op(3'd2, 32'd5, 32'd0, "div_zero");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd0, "div_zero_neg");
    run_op(3'd3, 32'hDEAD_BEEF, 32'd0, "divu_zero");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd2, 32'd7, -32'sd2, "div_negdivisor");
    run_op(3'd3, 32'hFFFF_FFFF, 32'h0000_0003, "divu_max");
    for (int i = 0; i < 4; i++) run_op(3'd2 + 3'(i % 2), $urandom, $urandom_range(1, 65535), "div_rand");
  endtask

  task automatic test_mthi_mtlo();
    write_hilo(3'd4, 32'hCAFE_0001, 1'b0, "mthi");
    write_hilo(3'd5, 32'hBEEF_0002, 1'b0, "mtlo");
    write_hilo(3'd4, 32'h0BAD_0BAD, 1'b1, "mthi_flushed");
    write_hilo(3'd6, 32'h0BAD_0BAD, 1'b0, "op6_ignored");
    write_hilo(3'd7, 32'h0BAD_0BAD, 1'b0, "op7_ignored");
    hilo_read = 1'b1; #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL idle_read_stall got=%b exp=0", stall); end
    hilo_read = 1'b0;
  endtask

  task automatic test_stall();
    logic [2*W-1:0] exp_hl;
    int bad, k;
    exp_q.push_back(model(3'd1, 32'h0001_0003, 32'h0002_0005));
    @(negedge clk);
    op = 3'd1; rs = 32'h0001_0003; rt = 32'h0002_0005; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    hilo_read = 1'b1; #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL stall_read got=%b exp=1", stall); end
    @(negedge clk);
    op = 3'd5; rs = 32'hDEAD_DEAD; start = 1'b1; #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL stall_start got=%b exp=1", stall); end
    @(posedge clk); #1;
    start = 1'b0;
    bad = 0;
    k = 0;
    while (busy && k < 100) begin
      if (stall !== 1'b1) bad++;
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (bad != 0 || busy !== 1'b0) begin failures++; $display("FAIL stall_hold bad_cycles=%0d busy=%b exp 0/0", bad, busy); end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL stall_release got=%b exp=0", stall); end
    hilo_read = 1'b0;
    exp_hl = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== exp_hl) begin failures++; $display("FAIL mtlo_during_busy got=%h exp=%h", {hi, lo}, exp_hl); end
  endtask

  task automatic test_flush_and_reset();
    logic [2*W-1:0] old_hl;
    write_hilo(3'd4, 32'h1111_2222, 1'b0, "pre_flush_hi");
    write_hilo(3'd5, 32'h3333_4444, 1'b0, "pre_flush_lo");
    old_hl = {hi, lo};
    @(negedge clk);
    op = 3'd0; rs = 32'd12345; rt = 32'd678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if ({hi, lo, busy} !== {old_hl, 1'b0}) begin
      failures++; $display("FAIL flush_run got hi=%h lo=%h busy=%b exp %h busy=0", hi, lo, busy, old_hl);
    end
    @(negedge clk);
    op = 3'd1; rs = 32'hFFFF_0000; rt = 32'h0000_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({hi, lo, busy} !== {64'd0, 1'b0}) begin
      failures++; $display("FAIL reset_mid_run got hi=%h lo=%h busy=%b exp 0", hi, lo, busy);
    end
  endtask

  task automatic test_back_to_back();
    run_op(3'd3, 32'd1000, 32'd33, "b2b_divu");
    run_op(3'd0, 32'd46341, 32'd46341, "b2b_mult");
    run_op(3'd2, -32'sd1000, -32'sd33, "b2b_div");
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_mthi_mtlo();
    test_stall();
    test_flush_and_reset();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
